// File: rtl/neighbor_count_sequencer_if.sv
// -----------------------------------------------------------------------------
// neighbor_count_sequencer_if
//   Request/response bundle between the cell-update logic (master) and the
//   neighbour count sequencer (slave).
//
//   Parameters
//     N             accumulator / count width
//     NUM_NEIGHBORS number of neighbour alive bits per request
//
//   Signals (direction as seen by the slave)
//     start      in   request, accepted only while ready=1
//     neighbors  in   neighbour alive bits, sampled on the accept edge
//     cell_alive in   current cell state, sampled on the accept edge
//     ready      out  sequencer idle and able to accept
//     busy       out  accumulation in progress
//     done       out  one-cycle pulse, count/next_alive valid
//     count      out  live-neighbour total, held until the next completion
//     next_alive out  next cell state
// -----------------------------------------------------------------------------
interface neighbor_count_sequencer_if #(
    parameter int N             = 4,
    parameter int NUM_NEIGHBORS = 8
);
    logic                     start;
    logic [NUM_NEIGHBORS-1:0] neighbors;
    logic                     cell_alive;
    logic                     ready;
    logic                     busy;
    logic                     done;
    logic [N-1:0]             count;
    logic                     next_alive;

    modport master (
        output start, neighbors, cell_alive,
        input  ready, busy, done, count, next_alive
    );

    modport slave (
        input  start, neighbors, cell_alive,
        output ready, busy, done, count, next_alive
    );
endinterface

// File: rtl/neighbor_count_sequencer.sv
// -----------------------------------------------------------------------------
// neighbor_count_sequencer
//   Counts the live neighbours of one Game of Life cell by pushing one
//   neighbour bit per clock through a single shared N-bit adder into an
//   accumulator. One request in flight; start/done handshake.
//
//   Build option
//     CONWAY_RULE_EN  when defined, next_alive is the Conway survival/birth
//                     result, registered together with count. When undefined,
//                     next_alive is tied low and cell_alive is ignored.
//
//   Ports
//     clk   in  system clock, rising edge
//     rst   in  asynchronous, active-high reset
//     bus   slave modport of neighbor_count_sequencer_if
//             start/neighbors/cell_alive in, ready/busy/done/count/next_alive out
//
//   Timing: accept on edge k, bits added on edges k+1..k+NUM_NEIGHBORS,
//   done high during the cycle after edge k+NUM_NEIGHBORS, back in IDLE one
//   edge later. Throughput is one request per NUM_NEIGHBORS+2 cycles.
// -----------------------------------------------------------------------------

// Plain N-bit ripple adder; the sequencer owns exactly one instance.
module adder_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);
    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};
endmodule

module neighbor_count_sequencer #(
    parameter int N             = 4,
    parameter int NUM_NEIGHBORS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    neighbor_count_sequencer_if.slave   bus
);
    localparam int IDX_W = (NUM_NEIGHBORS > 1) ? $clog2(NUM_NEIGHBORS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEIGHBORS - 1);

    // The accumulator must hold NUM_NEIGHBORS without overflowing.
    if (NUM_NEIGHBORS < 1) begin : g_bad_num
        $error("neighbor_count_sequencer: NUM_NEIGHBORS must be >= 1");
    end
    if ((2 ** N) <= NUM_NEIGHBORS) begin : g_bad_n
        $error("neighbor_count_sequencer: 2**N must exceed NUM_NEIGHBORS");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [N-1:0]             acc_q, acc_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [NUM_NEIGHBORS-1:0] nbr_q, nbr_d;
    logic [N-1:0]             count_q, count_d;
    logic                     next_alive_q, next_alive_d;

    logic                     ready, busy, done;
    logic [N-1:0]             adder_b;
    logic [N-1:0]             adder_sum;
    // Carry-out cannot be 1 while 2**N > NUM_NEIGHBORS; kept only for the check.
    logic                     unused_c_out;

    // Current neighbour bit, zero-extended to adder width.
    assign adder_b = N'(nbr_q[idx_q]);

    adder_n #(.N(N)) u_adder (
        .a     (acc_q),
        .b     (adder_b),
        .c_in  (1'b0),
        .sum   (adder_sum),
        .c_out (unused_c_out)
    );

`ifdef CONWAY_RULE_EN
    logic cell_alive_q, cell_alive_d;
    logic rule_alive;

    // Birth on exactly 3, survival on 2 or 3, evaluated on the final sum.
    assign rule_alive = (adder_sum == N'(3)) | (cell_alive_q & (adder_sum == N'(2)));
`else
    logic unused_cell_alive;
    assign unused_cell_alive = bus.cell_alive;
`endif

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        nbr_d        = nbr_q;
        count_d      = count_q;
        next_alive_d = next_alive_q;
`ifdef CONWAY_RULE_EN
        cell_alive_d = cell_alive_q;
`endif
        ready        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.start) begin
                    nbr_d   = bus.neighbors;
                    acc_d   = '0;
                    idx_d   = '0;
`ifdef CONWAY_RULE_EN
                    cell_alive_d = bus.cell_alive;
`endif
                    state_d = ACCUM;
                end
            end

            ACCUM: begin
                busy  = 1'b1;
                acc_d = adder_sum;
                if (idx_q == LAST_IDX) begin
                    // Last bit: publish the total; idx stays put rather than wrap.
                    count_d = adder_sum;
`ifdef CONWAY_RULE_EN
                    next_alive_d = rule_alive;
`else
                    next_alive_d = 1'b0;
`endif
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its _d, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the latched neighbour bits are a handful of flops, so they
            // are reset with the rest of the state for a fully known start-up.
            state_q      <= IDLE;
            acc_q        <= '0;
            idx_q        <= '0;
            nbr_q        <= '0;
            count_q      <= '0;
            next_alive_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            nbr_q        <= nbr_d;
            count_q      <= count_d;
            next_alive_q <= next_alive_d;
        end
    end

`ifdef CONWAY_RULE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cell_alive_q <= 1'b0;
        end else begin
            cell_alive_q <= cell_alive_d;
        end
    end
`endif

    assign bus.ready      = ready;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.count      = count_q;
    assign bus.next_alive = next_alive_q;

`ifdef SIMULATION
    always @(posedge clk) begin
        if (!rst) begin
            assert (unused_c_out == 1'b0)
                else $error("neighbor_count_sequencer: adder carry-out set");
        end
    end
`endif
endmodule
